ddfs_phase_front: RTL and testbench

Phase-generation front end of the DDFS datapath, sitting directly upstream of the MBRT rotation stage. It holds the frequency control word (FCW), runs the phase accumulator, addresses the external coarse/fine sin-cos ROM, and re-times the ROM word. It then presents `lut_data`, `phi_rot` and `en` to the rotator, cycle-aligned and with a valid flag.

---
 rtl/ddfs_phase_front.sv | 179 +++++++++++++++++
 tb/tb_ddfs_phase_front.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ddfs_phase_front.sv
// ddfs_phase_front
// Phase-generation front end of the DDFS datapath. It sits upstream of the
// MBRT rotator and does four jobs:
//   - holds the frequency control word (immediate or deferred-to-wrap load)
//   - runs the phase accumulator
//   - addresses the external coarse/fine sin-cos ROM
//   - re-times the ROM word, together with the rotation word and the stage
//     enables, so that all of them arrive at the rotator on the same cycle
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   run               : accumulator advances while high, holds while low
//   fcw_data/valid    : FCW offer; fcw_ready is high only in IDLE
//   fcw_at_wrap       : 1 = defer the offered FCW to the next carry, 0 = apply now
//   phase_clr         : zero the accumulator; also releases a pending FCW
//   rot_en_mask       : stage enables, delayed to line up with lut_data (en)
//   rom_addr/rom_data : registered ROM address, synchronous ROM word (1-cycle read)
//   lut_data, phi_rot, en, out_valid : rotator-facing outputs, cycle aligned
//   wrap              : one-cycle pulse on accumulator carry-out
//
// Optional feature: define DDFS_PHASE_DITHER_EN to add LFSR dither into the
// truncated LSBs before the address/rotation slice. The accumulator itself
// is left untouched. With the macro undefined, rom_addr and phi_rot are
// exact slices of the accumulator.
module ddfs_phase_front #(
  parameter int ACC_W = 24,
  parameter int AW    = 8,
  parameter int ROT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [ACC_W-1:0] fcw_data,
  input  logic             fcw_valid,
  output logic             fcw_ready,
  input  logic             fcw_at_wrap,
  input  logic             phase_clr,
  input  logic [2:0]       rot_en_mask,
  output logic [AW-1:0]    rom_addr,
  input  logic [63:0]      rom_data,
  output logic [63:0]      lut_data,
  output logic [ROT_W-1:0] phi_rot,
  output logic [2:0]       en,
  output logic             out_valid,
  output logic             wrap
);

  // Path from address register to captured ROM word is 3 edges.
  localparam int STAGES  = 3;
  localparam int TRUNC_W = ACC_W - AW - ROT_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  logic [ACC_W-1:0]             acc_q, acc_d;
  logic [ACC_W-1:0]             fcw_act_q, fcw_act_d;
  logic [ACC_W-1:0]             fcw_pend_q, fcw_pend_d;
  logic [0:0]                   state_q, state_d;
  logic                         wrap_q, wrap_d;
  logic [AW-1:0]                rom_addr_q, rom_addr_d;
  logic [63:0]                  lut_q, lut_d;
  logic [STAGES:1]              vld_pipe_q, vld_pipe_d;
  logic [STAGES:1][ROT_W-1:0]   phi_pipe_q, phi_pipe_d;
  logic [STAGES:1][2:0]         en_pipe_q, en_pipe_d;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] ph;
  logic             unused_trunc;

  assign sum   = {1'b0, acc_q} + {1'b0, fcw_act_q};
  assign carry = run & sum[ACC_W];

`ifdef DDFS_PHASE_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,15,13,4 (maximal length).
  always_comb begin
    lfsr_d = lfsr_q;
    if (run) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  // Dither only feeds the slice; the carry may ripple into phi_rot and rom_addr.
  assign ph = acc_q + {{(ACC_W-TRUNC_W){1'b0}}, lfsr_q[TRUNC_W-1:0]};
`else
  assign ph = acc_q;
`endif

  assign unused_trunc = ^ph[TRUNC_W-1:0];

  // Accumulator: clear beats the add and suppresses the carry pulse.
  always_comb begin
    acc_d  = acc_q;
    wrap_d = 1'b0;
    if (phase_clr) begin
      acc_d = '0;
    end else if (run) begin
      acc_d  = sum[ACC_W-1:0];
      wrap_d = sum[ACC_W];
    end
  end

  // FCW load FSM. Offers are only looked at in IDLE.
  always_comb begin
    state_d    = state_q;
    fcw_act_d  = fcw_act_q;
    fcw_pend_d = fcw_pend_q;
    case (state_q)
      S_IDLE: begin
        if (fcw_valid) begin
          if (fcw_at_wrap) begin
            fcw_pend_d = fcw_data;
            state_d    = S_PEND;
          end else begin
            fcw_act_d  = fcw_data;
          end
        end
      end
      default: begin
        // A clear releases the pending word too, so FCW=0 cannot lock it up.
        if (phase_clr || carry) begin
          fcw_act_d = fcw_pend_q;
          state_d   = S_IDLE;
        end
      end
    endcase
  end

  // Address / rotation split and alignment pipeline.
  always_comb begin
    rom_addr_d = ph[ACC_W-1 -: AW];
    lut_d      = rom_data;
    phi_pipe_d = {phi_pipe_q[STAGES-1:1], ph[ACC_W-AW-1 -: ROT_W]};
    en_pipe_d  = {en_pipe_q[STAGES-1:1], rot_en_mask};
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], run};
    // Data in flight belongs to the pre-clear phase; mark it all invalid.
    if (phase_clr) vld_pipe_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      fcw_act_q  <= '0;
      fcw_pend_q <= '0;
      state_q    <= S_IDLE;
      wrap_q     <= 1'b0;
      rom_addr_q <= '0;
      lut_q      <= '0;
      vld_pipe_q <= '0;
      phi_pipe_q <= '0;
      en_pipe_q  <= '0;
    end else begin
      acc_q      <= acc_d;
      fcw_act_q  <= fcw_act_d;
      fcw_pend_q <= fcw_pend_d;
      state_q    <= state_d;
      wrap_q     <= wrap_d;
      rom_addr_q <= rom_addr_d;
      lut_q      <= lut_d;
      vld_pipe_q <= vld_pipe_d;
      phi_pipe_q <= phi_pipe_d;
      en_pipe_q  <= en_pipe_d;
    end
  end

  assign fcw_ready = (state_q == S_IDLE);
  assign rom_addr  = rom_addr_q;
  assign lut_data  = lut_q;
  assign phi_rot   = phi_pipe_q[STAGES];
  assign en        = en_pipe_q[STAGES];
  assign out_valid = vld_pipe_q[STAGES];
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_ddfs_phase_front.sv
// Directed bench for ddfs_phase_front (dither disabled). A tiny synchronous
// ROM model returns a per-address pattern so that lut_data alignment can be
// checked. Inputs change and outputs are sampled on the falling edge.
module tb_ddfs_phase_front;

  logic        clk = 1'b0;
  logic        rst, run, fcw_valid, fcw_ready, fcw_at_wrap, phase_clr;
  logic [23:0] fcw_data;
  logic [2:0]  rot_en_mask, en;
  logic [7:0]  rom_addr;
  logic [63:0] rom_data = 64'h0;
  logic [63:0] lut_data;
  logic [8:0]  phi_rot;
  logic        out_valid, wrap;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] wrap_addr [5] = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd0};
  logic       wrap_exp  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  function automatic logic [63:0] rom_f(input logic [7:0] a);
    return {8{a}} ^ 64'hA5A5_0F0F_3C3C_9696;
  endfunction

  always @(posedge clk) rom_data <= rom_f(rom_addr);

  ddfs_phase_front dut (
    .clk(clk), .rst(rst), .run(run),
    .fcw_data(fcw_data), .fcw_valid(fcw_valid), .fcw_ready(fcw_ready),
    .fcw_at_wrap(fcw_at_wrap), .phase_clr(phase_clr), .rot_en_mask(rot_en_mask),
    .rom_addr(rom_addr), .rom_data(rom_data), .lut_data(lut_data),
    .phi_rot(phi_rot), .en(en), .out_valid(out_valid), .wrap(wrap)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_now(input logic [23:0] w);
    fcw_valid = 1'b1; fcw_data = w; fcw_at_wrap = 1'b0;
    step();
    fcw_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; fcw_valid = 1'b0; fcw_data = '0;
    fcw_at_wrap = 1'b0; phase_clr = 1'b0; rot_en_mask = 3'b000;
    @(negedge clk);
    step(); step();

    // reset state
    chk("rst_addr",  64'(rom_addr),  64'h0);
    chk("rst_lut",   lut_data,       64'h0);
    chk("rst_phi",   64'(phi_rot),   64'h0);
    chk("rst_en",    64'(en),        64'h0);
    chk("rst_vld",   64'(out_valid), 64'h0);
    chk("rst_wrap",  64'(wrap),      64'h0);
    chk("rst_ready", 64'(fcw_ready), 64'h1);

    // basic stream, FCW 0x010000 loaded immediately
    rst = 1'b0; rot_en_mask = 3'b101;
    load_now(24'h010000);
    run = 1'b1;
    step(); chk("bas_addr1", 64'(rom_addr), 64'h0); chk("bas_vld1", 64'(out_valid), 64'h0);
    step(); chk("bas_addr2", 64'(rom_addr), 64'h1); chk("bas_vld2", 64'(out_valid), 64'h0);
    step(); chk("bas_addr3", 64'(rom_addr), 64'h2); chk("bas_vld3", 64'(out_valid), 64'h1);
    chk("bas_lut0", lut_data, rom_f(8'd0));
    chk("bas_en",   64'(en),  64'h5);
    step(); chk("bas_lut1", lut_data, rom_f(8'd1));

    // reset mid-stream
    rst = 1'b1;
    step();
    chk("mrst_addr", 64'(rom_addr),  64'h0);
    chk("mrst_lut",  lut_data,       64'h0);
    chk("mrst_vld",  64'(out_valid), 64'h0);
    chk("mrst_en",   64'(en),        64'h0);

    // wrap every 4th cycle with FCW 0x400000
    rst = 1'b0; run = 1'b0;
    load_now(24'h400000);
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("wrp_addr%0d", i), 64'(rom_addr), 64'(wrap_addr[i]));
      chk($sformatf("wrp_pulse%0d", i), 64'(wrap), 64'(wrap_exp[i]));
    end

    // deferred FCW 0x200000; an offer while not ready must be dropped
    fcw_valid = 1'b1; fcw_data = 24'h200000; fcw_at_wrap = 1'b1;
    step(); chk("dfr_rdy0", 64'(fcw_ready), 64'h0);
    fcw_data = 24'h111111; fcw_at_wrap = 1'b0;
    step(); chk("dfr_rdy1", 64'(fcw_ready), 64'h0);
    fcw_valid = 1'b0;
    step(); chk("dfr_rdy2", 64'(fcw_ready), 64'h1); chk("dfr_wrap", 64'(wrap), 64'h1);
    step(); chk("dfr_addr0", 64'(rom_addr), 64'h00);
    step(); chk("dfr_addr1", 64'(rom_addr), 64'h20);
    step(); chk("dfr_addr2", 64'(rom_addr), 64'h40);

    // clear at acc=0x7F0000 with FCW 0x300000 pending
    rst = 1'b1; run = 1'b0; step(); rst = 1'b0;
    load_now(24'h010000);
    run = 1'b1; fcw_valid = 1'b1; fcw_data = 24'h300000; fcw_at_wrap = 1'b1;
    step(); fcw_valid = 1'b0;
    repeat (126) step();
    chk("clr_pend", 64'(fcw_ready), 64'h0);
    phase_clr = 1'b1;
    step(); phase_clr = 1'b0;
    chk("clr_rdy",   64'(fcw_ready), 64'h1);
    chk("clr_vld0",  64'(out_valid), 64'h0);
    chk("clr_addr0", 64'(rom_addr),  64'h7F);
    step(); chk("clr_vld1", 64'(out_valid), 64'h0); chk("clr_addr1", 64'(rom_addr), 64'h00);
    step(); chk("clr_vld2", 64'(out_valid), 64'h0); chk("clr_addr2", 64'(rom_addr), 64'h30);
    step(); chk("clr_vld3", 64'(out_valid), 64'h1); chk("clr_addr3", 64'(rom_addr), 64'h60);
    // acc now 0x900000; two more adds reach 0xF00000, then clear on the carry
    step(); step();
    phase_clr = 1'b1;
    step(); phase_clr = 1'b0;
    chk("clrw_wrap", 64'(wrap), 64'h0);
    chk("clrw_addr", 64'(rom_addr), 64'hF0);
    step(); chk("clrw_addr2", 64'(rom_addr), 64'h00);

    // FCW = 0: no wrap, pending word stays pending until reset discards it
    rst = 1'b1; step(); rst = 1'b0;
    run = 1'b1; fcw_valid = 1'b1; fcw_data = 24'h800000; fcw_at_wrap = 1'b1;
    step(); fcw_valid = 1'b0;
    repeat (20) step();
    chk("z_rdy",  64'(fcw_ready), 64'h0);
    chk("z_wrap", 64'(wrap),      64'h0);
    chk("z_addr", 64'(rom_addr),  64'h0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("z_rst_rdy", 64'(fcw_ready), 64'h1);
    repeat (3) step();
    chk("z_rst_addr", 64'(rom_addr), 64'h0);

    // split check, FCW 0x80: phi_rot +1 per cycle, rom_addr +1 per 512
    rst = 1'b1; run = 1'b0; step(); rst = 1'b0;
    load_now(24'h000080);
    run = 1'b1;
    step(); step(); step();
    chk("spl_phi0", 64'(phi_rot), 64'd0);
    step(); chk("spl_phi1", 64'(phi_rot), 64'd1);
    step(); chk("spl_phi2", 64'(phi_rot), 64'd2);
    repeat (507) step();
    chk("spl_addr0", 64'(rom_addr), 64'h0);
    step();
    chk("spl_addr1", 64'(rom_addr), 64'h1);
    chk("spl_phi510", 64'(phi_rot), 64'd510);

    // run low: out_valid drops on the 3rd edge, phase frozen
    run = 1'b0;
    step(); step();
    chk("stop_vld2", 64'(out_valid), 64'h1);
    step();
    chk("stop_vld3", 64'(out_valid), 64'h0);
    chk("stop_addr", 64'(rom_addr),  64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
